// File: rtl/csi_rx_packet_handler.sv
// csi_rx_packet_handler: CSI-2 packet header decoder and payload filter.
// Takes aligned 32-bit words from the lane aligner, forwards matching
// long-packet payload and turns FS/FE/LS/LE short packets into strobes.
// Optional header ECC check: define CSI_RX_ECC_CHECK_EN.
module csi_rx_packet_handler #(
  parameter logic [5:0] DATA_TYPE = 6'h2C,
  parameter logic [1:0] VIRT_CHAN = 2'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] data_in,
  input  logic        din_valid,
  output logic [31:0] data_out,
  output logic        dout_valid,
  output logic        frame_start,
  output logic        frame_end,
  output logic        line_start,
  output logic        line_end,
  output logic        in_frame,
  output logic        trunc_error,
  output logic        ecc_error
);

  typedef enum logic [1:0] {IDLE, PAYLOAD, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [31:0] data_q, data_d;
  logic        in_frame_q, in_frame_d;
  logic        dv_q, dv_d;
  logic        fs_q, fs_d, fe_q, fe_d, ls_q, ls_d, le_q, le_d;
  logic        tr_q, tr_d, ecc_q, ecc_d;

  logic [1:0]  hdr_vc;
  logic [5:0]  hdr_dt;
  logic [15:0] hdr_wc;
  logic        hdr_ecc_ok;

  assign hdr_vc = data_in[7:6];
  assign hdr_dt = data_in[5:0];
  assign hdr_wc = {data_in[23:16], data_in[15:8]};

`ifdef CSI_RX_ECC_CHECK_EN
  logic [23:0] d;
  logic [5:0]  ecc_calc;
  assign d = data_in[23:0];

  // Header Hamming parity over the 24 header data bits
  always_comb begin
    ecc_calc[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    ecc_calc[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    ecc_calc[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    ecc_calc[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    ecc_calc[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    ecc_calc[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
  end

  assign hdr_ecc_ok = (data_in[29:24] == ecc_calc) && (data_in[31:30] == 2'b00);
`else
  logic unused_ecc_byte;
  assign unused_ecc_byte = ^data_in[31:24];
  assign hdr_ecc_ok      = 1'b1;
`endif

  // Next-state, counter, payload and strobe decode
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    data_d     = data_q;
    in_frame_d = in_frame_q;
    dv_d       = 1'b0;
    fs_d       = 1'b0;
    fe_d       = 1'b0;
    ls_d       = 1'b0;
    le_d       = 1'b0;
    tr_d       = 1'b0;
    ecc_d      = 1'b0;
    if (enable) begin
      case (state_q)
        IDLE: begin
          if (din_valid) begin
            if (!hdr_ecc_ok) begin
              ecc_d   = 1'b1;
              state_d = DRAIN;
            end else if (hdr_dt < 6'h10) begin
              case (hdr_dt)
                6'h00: begin fs_d = 1'b1; in_frame_d = 1'b1; end
                6'h01: begin fe_d = 1'b1; in_frame_d = 1'b0; end
                6'h02: ls_d = 1'b1;
                6'h03: le_d = 1'b1;
                default: ;
              endcase
              state_d = DRAIN;
            end else if (hdr_dt == DATA_TYPE && hdr_vc == VIRT_CHAN && hdr_wc != '0) begin
              count_d = hdr_wc;
              state_d = PAYLOAD;
            end else begin
              state_d = DRAIN;
            end
          end
        end
        PAYLOAD: begin
          if (din_valid) begin
            dv_d = 1'b1;
            if (count_q <= 16'd4) begin
              for (int unsigned b = 0; b < 4; b++)
                data_d[8*b +: 8] = (b < 32'(count_q)) ? data_in[8*b +: 8] : '0;
              le_d    = 1'b1;
              count_d = '0;
              state_d = DRAIN;
            end else begin
              data_d  = data_in;
              count_d = count_q - 16'd4;
            end
          end else begin
            tr_d    = 1'b1;
            count_d = '0;
            state_d = IDLE;
          end
        end
        DRAIN: begin
          if (!din_valid) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      data_q     <= '0;
      in_frame_q <= 1'b0;
      dv_q       <= 1'b0;
      fs_q       <= 1'b0;
      fe_q       <= 1'b0;
      ls_q       <= 1'b0;
      le_q       <= 1'b0;
      tr_q       <= 1'b0;
      ecc_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      data_q     <= data_d;
      in_frame_q <= in_frame_d;
      dv_q       <= dv_d;
      fs_q       <= fs_d;
      fe_q       <= fe_d;
      ls_q       <= ls_d;
      le_q       <= le_d;
      tr_q       <= tr_d;
      ecc_q      <= ecc_d;
    end
  end

  assign data_out    = data_q;
  assign dout_valid  = dv_q;
  assign frame_start = fs_q;
  assign frame_end   = fe_q;
  assign line_start  = ls_q;
  assign line_end    = le_q;
  assign in_frame    = in_frame_q;
  assign trunc_error = tr_q;
  assign ecc_error   = ecc_q;

endmodule

// File: tb/tb_csi_rx_packet_handler.sv
// Testbench for csi_rx_packet_handler: packet-level reference model builds the
// expected per-cycle output trace alongside the stimulus.
module tb_csi_rx_packet_handler;

  logic        clock = 1'b0;
  logic        reset, enable, din_valid;
  logic [31:0] data_in, data_out;
  logic        dout_valid, frame_start, frame_end, line_start, line_end;
  logic        in_frame, trunc_error, ecc_error;

  int total = 0;
  int bad   = 0;

`ifdef CSI_RX_ECC_CHECK_EN
  localparam bit ECC_ON = 1'b1;
`else
  localparam bit ECC_ON = 1'b0;
`endif

  // Syndrome column of each header data bit
  localparam logic [5:0] ECC_COL [24] = '{
    6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
    6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
    6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};

  csi_rx_packet_handler #(.DATA_TYPE(6'h2C), .VIRT_CHAN(2'd0)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .data_in(data_in), .din_valid(din_valid),
    .data_out(data_out), .dout_valid(dout_valid),
    .frame_start(frame_start), .frame_end(frame_end),
    .line_start(line_start), .line_end(line_end),
    .in_frame(in_frame), .trunc_error(trunc_error), .ecc_error(ecc_error));

  always #5 clock = ~clock;

  // Stimulus per cycle and expected outputs after the edge that samples it
  logic [31:0] sd[$];
  logic        sv[$], se[$], sr[$];
  logic [39:0] ex[$], obs[$];
  logic        mf    = 1'b0;
  logic [31:0] mlast = '0;

  function automatic logic [5:0] ecc_of(input logic [23:0] h);
    logic [5:0] e = '0;
    for (int i = 0; i < 24; i++) if (h[i]) e = e ^ ECC_COL[i];
    return e;
  endfunction

  function automatic logic [31:0] hdr(input logic [1:0] vc, input logic [5:0] dt,
                                      input logic [15:0] wc, input logic [5:0] flip);
    logic [23:0] h = {wc, vc, dt};
    return {2'b00, ecc_of(h) ^ flip, h};
  endfunction

  // p = {fs, fe, ls, le, trunc, ecc}
  task automatic push(input logic [31:0] d, input logic v, input logic en, input logic rst,
                      input logic dv, input logic [31:0] dout, input logic [5:0] p);
    sd.push_back(d); sv.push_back(v); se.push_back(en); sr.push_back(rst);
    if (rst) begin
      mf = 1'b0; mlast = '0;
    end else begin
      if (p[5]) mf = 1'b1;
      if (p[4]) mf = 1'b0;
      if (dv) mlast = dout;
    end
    ex.push_back({mlast, dv, p[5:2], mf, p[1:0]});
  endtask

  task automatic idle(input int n);
    repeat (n) push($urandom, 1'b0, 1'b1, 1'b0, 1'b0, '0, 6'b0);
  endtask

  task automatic clear();
    sd.delete(); sv.delete(); se.delete(); sr.delete(); ex.delete(); obs.delete();
  endtask

  task automatic play();
    for (int i = 0; i < sd.size(); i++) begin
      data_in = sd[i]; din_valid = sv[i]; enable = se[i]; reset = sr[i];
      @(posedge clock); #1;
      obs.push_back({data_out, dout_valid, frame_start, frame_end, line_start,
                     line_end, in_frame, trunc_error, ecc_error});
    end
    din_valid = 1'b0; enable = 1'b1; reset = 1'b0;
  endtask

  task automatic pkt_short(input logic [1:0] vc, input logic [5:0] dt, input logic [5:0] flip);
    logic bad_hdr = ECC_ON && (flip != 6'h0);
    logic [5:0] p = bad_hdr ? 6'b000001
                            : {dt == 6'h00, dt == 6'h01, dt == 6'h02, dt == 6'h03, 2'b00};
    push(hdr(vc, dt, 16'($urandom), flip), 1'b1, 1'b1, 1'b0, 1'b0, '0, p);
    idle(1 + int'($urandom_range(0, 2)));
  endtask

  task automatic pkt_long(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc,
                          input logic [5:0] flip, input bit ramp, input int trunc_at,
                          input int stall_at);
    logic bad_hdr = ECC_ON && (flip != 6'h0);
    logic accept  = !bad_hdr && dt == 6'h2C && vc == 2'd0 && wc != 16'h0;
    int n = (int'(wc) + 3) / 4;
    push(hdr(vc, dt, wc, flip), 1'b1, 1'b1, 1'b0, 1'b0, '0, {5'b0, bad_hdr});
    for (int k = 0; k < n; k++) begin
      logic [31:0] w, e;
      int rem = int'(wc) - 4 * k;
      if (trunc_at == k) begin
        push($urandom, 1'b0, 1'b1, 1'b0, 1'b0, '0, {4'b0, accept, 1'b0});
        idle(1);
        return;
      end
      w = ramp ? {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)} : $urandom;
      if (stall_at == k) repeat (3) push(w, 1'b1, 1'b0, 1'b0, 1'b0, '0, 6'b0);
      e = (rem < 4) ? (w & ((32'h1 << (8 * rem)) - 32'h1)) : w;
      push(w, 1'b1, 1'b1, 1'b0, accept, e, {3'b000, accept && rem <= 4, 2'b00});
    end
    push($urandom, 1'b1, 1'b1, 1'b0, 1'b0, '0, 6'b0);
    idle(1 + int'($urandom_range(0, 1)));
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; din_valid = 1'b1; data_in = 32'h0000_0000;
    repeat (2) begin
      @(posedge clock); #1;
      total++;
      if ({data_out, dout_valid, frame_start, frame_end, line_start, line_end,
           in_frame, trunc_error, ecc_error} !== 40'h0) begin
        bad++;
        $display("FAIL reset_state: got %h expected %h", {data_out, dout_valid, frame_start,
                 frame_end, line_start, line_end, in_frame, trunc_error, ecc_error}, 40'h0);
      end
    end
    reset = 1'b0; din_valid = 1'b0;
    mf = 1'b0; mlast = '0;
  endtask

  task automatic test_short_packets();
    clear();
    pkt_short(2'd0, 6'h00, 6'h0);
    pkt_short(2'd0, 6'h02, 6'h0);
    pkt_short(2'd0, 6'h03, 6'h0);
    pkt_short(2'd0, 6'h01, 6'h0);
    for (int i = 0; i < 4; i++) pkt_short(2'd0, 6'($urandom_range(4, 15)), 6'h0);
    pkt_short(2'd0, 6'h00, 6'h0);
    pkt_short(2'd0, 6'h01, 6'h0);
    play();
    for (int i = 0; i < ex.size(); i++) begin
      total++;
      if (obs[i] !== ex[i]) begin
        bad++;
        $display("FAIL short_packets cycle %0d: got %h expected %h", i, obs[i], ex[i]);
      end
    end
  endtask

  task automatic test_long_packets();
    clear();
    pkt_short(2'd0, 6'h00, 6'h0);
    pkt_long(2'd0, 6'h2C, 16'd12, 6'h0, 1'b1, -1, -1);
    pkt_long(2'd0, 6'h2C, 16'd10, 6'h0, 1'b1, -1, -1);
    for (int i = 0; i < 8; i++)
      pkt_long(2'd0, 6'h2C, 16'($urandom_range(1, 64)), 6'h0, 1'b0, -1, -1);
    pkt_short(2'd0, 6'h01, 6'h0);
    play();
    for (int i = 0; i < ex.size(); i++) begin
      total++;
      if (obs[i] !== ex[i]) begin
        bad++;
        $display("FAIL long_packets cycle %0d: got %h expected %h", i, obs[i], ex[i]);
      end
    end
  endtask

  task automatic test_filtering();
    clear();
    pkt_long(2'd0, 6'h2B, 16'd8, 6'h0, 1'b0, -1, -1);
    pkt_long(2'd1, 6'h2C, 16'd12, 6'h0, 1'b0, -1, -1);
    pkt_long(2'd0, 6'h2C, 16'd0, 6'h0, 1'b0, -1, -1);
    for (int i = 0; i < 4; i++)
      pkt_long(2'($urandom), 6'($urandom_range(16, 43)), 16'($urandom_range(1, 32)),
               6'h0, 1'b0, -1, -1);
    pkt_short(2'd0, 6'h00, 6'h0);
    pkt_long(2'd0, 6'h2C, 16'd7, 6'h0, 1'b0, -1, -1);
    play();
    for (int i = 0; i < ex.size(); i++) begin
      total++;
      if (obs[i] !== ex[i]) begin
        bad++;
        $display("FAIL filtering cycle %0d: got %h expected %h", i, obs[i], ex[i]);
      end
    end
  endtask

  task automatic test_truncation();
    clear();
    pkt_long(2'd0, 6'h2C, 16'd16, 6'h0, 1'b0, 2, -1);
    pkt_long(2'd0, 6'h2C, 16'd8, 6'h0, 1'b0, -1, -1);
    pkt_long(2'd0, 6'h2C, 16'd20, 6'h0, 1'b0, 0, -1);
    pkt_long(2'd0, 6'h2C, 16'd24, 6'h0, 1'b0, int'($urandom_range(1, 5)), -1);
    pkt_short(2'd0, 6'h02, 6'h0);
    play();
    for (int i = 0; i < ex.size(); i++) begin
      total++;
      if (obs[i] !== ex[i]) begin
        bad++;
        $display("FAIL truncation cycle %0d: got %h expected %h", i, obs[i], ex[i]);
      end
    end
  endtask

  task automatic test_ecc();
    clear();
    pkt_long(2'd0, 6'h2C, 16'd8, 6'h0, 1'b0, -1, -1);
    pkt_long(2'd0, 6'h2C, 16'd8, 6'h01, 1'b0, -1, -1);
    pkt_long(2'd0, 6'h2C, 16'd12, 6'(1 << $urandom_range(0, 5)), 1'b0, -1, -1);
    pkt_short(2'd0, 6'h00, 6'h01);
    pkt_short(2'd0, 6'h00, 6'h0);
    pkt_long(2'd0, 6'h2C, 16'd5, 6'h0, 1'b0, -1, -1);
    play();
    for (int i = 0; i < ex.size(); i++) begin
      total++;
      if (obs[i] !== ex[i]) begin
        bad++;
        $display("FAIL ecc cycle %0d: got %h expected %h", i, obs[i], ex[i]);
      end
    end
  endtask

  task automatic test_enable_stall();
    clear();
    pkt_long(2'd0, 6'h2C, 16'd20, 6'h0, 1'b1, -1, 2);
    pkt_long(2'd0, 6'h2C, 16'd14, 6'h0, 1'b0, -1, 3);
    pkt_long(2'd0, 6'h2C, 16'd32, 6'h0, 1'b0, -1, int'($urandom_range(0, 7)));
    play();
    for (int i = 0; i < ex.size(); i++) begin
      total++;
      if (obs[i] !== ex[i]) begin
        bad++;
        $display("FAIL enable_stall cycle %0d: got %h expected %h", i, obs[i], ex[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] w;
    clear();
    pkt_short(2'd0, 6'h00, 6'h0);
    push(hdr(2'd0, 6'h2C, 16'd16, 6'h0), 1'b1, 1'b1, 1'b0, 1'b0, '0, 6'b0);
    for (int k = 0; k < 2; k++) begin
      w = $urandom;
      push(w, 1'b1, 1'b1, 1'b0, 1'b1, w, 6'b0);
    end
    push($urandom, 1'b1, 1'b1, 1'b1, 1'b0, '0, 6'b0);
    idle(2);
    pkt_long(2'd0, 6'h2C, 16'd9, 6'h0, 1'b0, -1, -1);
    play();
    for (int i = 0; i < ex.size(); i++) begin
      total++;
      if (obs[i] !== ex[i]) begin
        bad++;
        $display("FAIL mid_reset cycle %0d: got %h expected %h", i, obs[i], ex[i]);
      end
    end
  endtask

  initial begin
    data_in = '0; din_valid = 1'b0; enable = 1'b1; reset = 1'b1;
    test_reset();
    test_short_packets();
    test_long_packets();
    test_filtering();
    test_truncation();
    test_ecc();
    test_enable_stall();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/csi_rx_packet_handler.md
Name: csi_rx_packet_handler

Overview:
- Sits directly upstream of the RAW12 unpacker, downstream of the 2-lane byte/word aligner.
- Consumes aligned 32-bit words, 4 bytes per cycle, with byte 0 in bits [7:0], valid from SoT to EoT.
- Decodes the CSI-2 packet header and forwards only matching long-packet payload as a contiguous valid stream.
- Strips header, CRC and trailer; decodes frame/line short packets into single-cycle strobes.

Parameters:
- DATA_TYPE, 6'h2C, long-packet data type to forward (RAW12).
- VIRT_CHAN, 2'd0, virtual channel to accept.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  clock enable; low freezes all state.
- data_in  in  32  aligned packet bytes; [7:0] is first in time.
- din_valid  in  1  high for every word from the first header word to the end of packet; low between packets.
- data_out  out  32  payload word, same byte order.
- dout_valid  out  1  payload qualifier; contiguous for a whole packet.
- frame_start  out  1  one-cycle pulse on FS short packet (DT 0x00).
- frame_end  out  1  one-cycle pulse on FE short packet (DT 0x01).
- line_start  out  1  one-cycle pulse on LS (DT 0x02).
- line_end  out  1  one-cycle pulse on LE (DT 0x03), or at the last payload word of an accepted long packet.
- in_frame  out  1  level: high after FS until FE.
- trunc_error  out  1  one-cycle pulse when din_valid drops before the word count is exhausted.
- ecc_error  out  1  one-cycle pulse on header ECC mismatch; 0 when the feature is absent.

Behaviour:
- Reset values:
  - All outputs 0.
  - data_out 0.
  - FSM in IDLE.
  - Remaining-byte counter 0.
- enable low:
  - FSM, counter and data_out hold their values.
  - dout_valid and all pulse outputs are 0 that cycle.
- Header decode:
  - Fields: DI = data_in[7:0] (VC = DI[7:6], DT = DI[5:0]); WC = {data_in[23:16], data_in[15:8]}; ECC = data_in[31:24].
- FSM states: IDLE, PAYLOAD, DRAIN.
- IDLE:
  - On din_valid, the word is a header.
  - DT < 0x10 (short packet): pulse the matching strobe one cycle after header arrival; update in_frame; go to DRAIN.
  - Long packet with DT == DATA_TYPE, VC == VIRT_CHAN and WC != 0: load counter = WC; go to PAYLOAD.
  - Any other long packet, or WC == 0: go to DRAIN.
- PAYLOAD:
  - Each din_valid word is registered to data_out with dout_valid = 1, one cycle after input.
  - Counter decrements by 4, saturating at 0.
  - When counter <= 4, this is the last word: bytes at index >= counter are zeroed, line_end pulses with it, and the FSM goes to DRAIN (discards CRC/trailer).
  - din_valid low in PAYLOAD: trunc_error pulses, no dout_valid, return to IDLE.
- DRAIN: discard words while din_valid is high; go to IDLE on the first cycle din_valid is low.
- din_valid low in IDLE or DRAIN: no effect beyond the return to IDLE.
- Simultaneity:
  - FE and FS never overlap (one header per packet).
  - A short packet in DRAIN is ignored, because a new header requires a din_valid low gap.
- Latency: header to strobe 1 cycle; payload word in to out 1 cycle, fixed.
- Reset mid-packet: returns to IDLE on the next edge. The remainder of that packet is decoded as a header plus words, so the aligner must also be reset; the bench resets both.
- in_frame: set on the FS pulse cycle; cleared on the FE pulse cycle.

Optional Feature:
- Macro: CSI_RX_ECC_CHECK_EN.
- With the macro:
  - Compute the 6-bit CSI-2 header Hamming ECC over data_in[23:0] and compare it with data_in[29:24]; data_in[31:30] must also be 0.
  - On mismatch, ecc_error pulses one cycle after the header, no strobe or payload is produced, and the FSM goes to DRAIN.
  - No single-bit correction.
- Without the macro: ecc_error is constant 0 and the ECC byte is ignored.

Test Plan:
- FS header 32'hxx000000 (VC 0) then din_valid low -> frame_start = 1 for exactly 1 cycle, 1 cycle after the header; in_frame = 1. FE header -> frame_end pulse; in_frame = 0.
- Long packet DT 0x2C, WC 12, payload words 32'h03020100, 32'h07060504, 32'h0B0A0908, then CRC word -> 3 consecutive dout_valid cycles carrying those exact values; line_end on the third; CRC not forwarded.
- Long packet DT 0x2C, WC 10 -> 3 words out; third word has bytes [31:16] = 0.
- Long packet DT 0x2B (RAW10) WC 8, and a DT 0x2C packet with VC 1 -> no dout_valid, no strobes; next FS is still decoded.
- DT 0x2C WC 16, din_valid dropped after 2 payload words -> 2 dout_valid cycles, trunc_error = 1 once, next header decoded normally.
- ECC checking (CSI_RX_ECC_CHECK_EN defined):
  - Correct ECC -> packet passes.
  - ECC bit 0 flipped -> ecc_error = 1 once, 0 dout_valid.
  - Without the macro, same stimulus passes the packet.
- enable held low for 3 cycles mid-payload, with the aligner stalled in step -> output stream resumes without loss or duplication.
- Reset asserted mid-payload -> all outputs 0 next cycle.
